alu_n_bit_mc: RTL and testbench
===============================

ALU_N_BIT_MC -- requirements
Module: alu_n_bit_mc

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 2..64.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset: sampled on rising CLK edge, 0 = reset.
REQ-004 start  input  1  request strobe; accepted only on an edge where busy=0.
REQ-005 a  input  WIDTH  operand A, two's complement.
REQ-006 b  input  WIDTH  operand B, two's complement.
REQ-007 ALUop  input  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 SLT, 101 ADD, 110 SUB, 111 MOD.
REQ-008 result  output  WIDTH  registered result of the last completed operation.
REQ-009 busy  output  1  high while a multi-cycle MOD is iterating.
REQ-010 done  output  1  one-cycle pulse; result and flags valid and updated on this cycle.
REQ-011 zero  output  1  result == 0, registered with result.
REQ-012 carry  output  1  ADD: carry-out of bit WIDTH-1; SUB: 1 when a >= b unsigned (no borrow); else 0.
REQ-013 overflow  output  1  signed overflow for ADD/SUB; else 0.
REQ-014 div_by_zero  output  1  set on MOD with b == 0; else 0.

Function
REQ-015 On acceptance, a, b and ALUop are captured internally; later input changes do not affect the operation in flight.
REQ-016 Ops 000-110 complete in one cycle: start accepted at edge k -> result/flags updated and done=1 at edge k+1; busy stays 0.
REQ-017 AND/OR/XOR/NOR are bitwise; NOR = ~(a|b).
REQ-018 SLT: result = 1 (zero-extended to WIDTH) when a < b signed, else 0; must be correct when a-b overflows.
REQ-019 ADD/SUB: result = (a+b) or (a-b) mod 2^WIDTH; overflow = operand signs agree (ADD) / differ (SUB) and result sign differs from a.
REQ-020 MOD: unsigned remainder a mod b via restoring shift-subtract, one quotient bit per cycle, WIDTH iterations.
REQ-021 MOD with b != 0: accepted at edge k -> busy=1 from edge k+1 through edge k+WIDTH; at edge k+WIDTH+1 busy=0, done=1, result = remainder.
REQ-022 MOD with b == 0: no iteration; at edge k+1 done=1, result = a, div_by_zero=1, busy never asserted.
REQ-023 State machine: IDLE -> (start, MOD, b!=0) -> DIV -> (iteration counter = WIDTH-1) -> FINISH -> IDLE; all other accepted starts complete directly from IDLE.
REQ-024 start while busy=1 is ignored: no capture, no extra done, in-flight MOD unaffected.
REQ-025 start on the done edge of a MOD (busy just low) is not accepted; start on the edge after done is accepted.
REQ-026 result and all flags hold their values between done pulses.
REQ-027 done is never high on two consecutive cycles for a single operation; back-to-back single-cycle ops with start held high produce done every cycle.

Reset
REQ-028 reset=0 at an edge forces: state IDLE, busy=0, done=0, result=0, zero=1, carry=0, overflow=0, div_by_zero=0, iteration counter=0.
REQ-029 reset=0 during a MOD aborts it; no done is produced for the aborted operation.
REQ-030 reset has priority over start on the same edge.

Verification (WIDTH=32)
REQ-031 AND a=0xAAAAAAAA, b=0x55555555 -> done at k+1, result=0x00000000, zero=1.
REQ-032 ADD a=0x7FFFFFFF, b=0x00000001 -> result=0x80000000, overflow=1, carry=0; SUB a=0x0000FFFF, b=0xFFFF0000 -> result=0x0001FFFF, carry=0, overflow=0.
REQ-033 SLT a=0xAAAAAAAA, b=0x55555555 -> result=1; SLT a=0x0000FFFF, b=0x0000000F -> result=0.
REQ-034 MOD a=32, b=9 -> busy high exactly 32 cycles, done at k+33, result=5; start pulses at k+5 and k+20 ignored.
REQ-035 MOD a=0x12345678, b=0 -> done at k+1, result=0x12345678, div_by_zero=1, busy=0 throughout.
REQ-036 MOD a=1000, b=7 with reset=0 at k+10 -> busy=0 and result=0 at k+11, no done; subsequent MOD a=1000, b=7 -> result=6.

Source files
------------

// File: rtl/alu_n_bit_mc.sv
// alu_n_bit_mc: multi-cycle N-bit ALU.
//   Logic, compare and add/sub operations finish in one cycle. MOD computes an
//   unsigned remainder with a restoring shift-subtract divider that produces
//   one quotient bit per cycle.
// Ports:
//   CLK          clock; all state changes on the rising edge
//   reset        synchronous, active-low reset
//   start        request strobe; taken only when the unit is idle
//   a, b         WIDTH-bit two's-complement operands
//   ALUop        000 AND, 001 OR, 010 XOR, 011 NOR, 100 SLT, 101 ADD, 110 SUB, 111 MOD
//   result       registered result of the last completed operation
//   busy         high while a MOD is iterating
//   done         one-cycle pulse when result and flags update
//   zero         result == 0
//   carry        ADD carry-out / SUB no-borrow (a >= b unsigned)
//   overflow     signed overflow for ADD/SUB
//   div_by_zero  MOD issued with b == 0
module alu_n_bit_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUop,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_FINISH
  } state_e;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOR = 3'b011,
    OP_SLT = 3'b100,
    OP_ADD = 3'b101,
    OP_SUB = 3'b110,
    OP_MOD = 3'b111
  } aluop_e;

  state_e state_q, state_d;
  aluop_e op;

  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

  // Divider working registers: divisor, shifting dividend, partial remainder.
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_nx;

  assign op     = aluop_e'(ALUop);
  assign accept = start && (state_q == S_IDLE);

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  // One restoring step. The partial remainder is always < divisor, so the
  // difference fits in WIDTH bits once the trial subtraction succeeds.
  assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
  assign rem_ge = (rem_sh >= {1'b0, div_q});
  assign rem_nx = WIDTH'(rem_ge ? (rem_sh - {1'b0, div_q}) : rem_sh);

  // State register
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && (op == OP_MOD) && (b != '0)) begin
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        if (cnt_q == LAST) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    div_d    = div_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (accept) begin
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          unique case (op)
            OP_AND: result_d = a & b;
            OP_OR:  result_d = a | b;
            OP_XOR: result_d = a ^ b;
            OP_NOR: result_d = ~(a | b);
            OP_SLT: result_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_ADD: begin
              result_d = sum_ext[WIDTH-1:0];
              carry_d  = sum_ext[WIDTH];
              ovf_d    = (a[WIDTH-1] == b[WIDTH-1]) &&
                         (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
              result_d = diff_ext[WIDTH-1:0];
              carry_d  = ~diff_ext[WIDTH];
              ovf_d    = (a[WIDTH-1] != b[WIDTH-1]) &&
                         (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MOD: begin
              if (b == '0) begin
                result_d = a;
                dbz_d    = 1'b1;
              end else begin
                // Hold outputs; the remainder arrives after WIDTH steps.
                done_d   = 1'b0;
                carry_d  = carry_q;
                ovf_d    = ovf_q;
                dbz_d    = dbz_q;
                busy_d   = 1'b1;
                div_d    = b;
                dvd_d    = a;
                rem_d    = '0;
                cnt_d    = '0;
              end
            end
            default: result_d = result_q;
          endcase
        end
      end
      S_DIV: begin
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        rem_d = rem_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          result_d = rem_nx;
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          dbz_d    = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          cnt_d    = '0;
        end
      end
      S_FINISH: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase

    zero_d = (result_d == '0);
  end

  // Datapath / output registers
  always_ff @(posedge CLK) begin
    if (!reset) begin
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      div_q    <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
    end else begin
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
      div_q    <= div_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result      = result_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign zero        = zero_q;
  assign carry       = carry_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_n_bit_mc.sv
// Directed testbench for alu_n_bit_mc at WIDTH=32.
module tb_alu_n_bit_mc;

  localparam int unsigned W = 32;

  localparam logic [2:0] AND_OP = 3'b000;
  localparam logic [2:0] OR_OP  = 3'b001;
  localparam logic [2:0] XOR_OP = 3'b010;
  localparam logic [2:0] NOR_OP = 3'b011;
  localparam logic [2:0] SLT_OP = 3'b100;
  localparam logic [2:0] ADD_OP = 3'b101;
  localparam logic [2:0] SUB_OP = 3'b110;
  localparam logic [2:0] MOD_OP = 3'b111;

  logic         CLK = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   ALUop;
  logic [W-1:0] result;
  logic         busy;
  logic         done;
  logic         zero;
  logic         carry;
  logic         overflow;
  logic         div_by_zero;

  int passed = 0;
  int total  = 0;

  alu_n_bit_mc #(.WIDTH(W)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .start       (start),
    .a           (a),
    .b           (b),
    .ALUop       (ALUop),
    .result      (result),
    .busy        (busy),
    .done        (done),
    .zero        (zero),
    .carry       (carry),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    ALUop = op;
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // n counts extra edges after the first observation; done offset = n + 1.
  task automatic wait_done(input int maxc, output int n, output logic ok);
    n  = 0;
    ok = 1'b0;
    while (n < maxc && !ok) begin
      if (done === 1'b1) ok = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  int          busy_cnt;
  int          done_cnt;
  int          done_at;
  logic [W-1:0] res_at;
  int          n;
  logic        ok;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    ALUop = AND_OP;
    tick();
    tick();
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_carry", carry, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_dbz", div_by_zero, 0);
    reset = 1'b1;
    tick();

    // AND
    issue(AND_OP, 32'hAAAAAAAA, 32'h55555555);
    chk("and_done", done, 1);
    chk("and_result", result, 0);
    chk("and_zero", zero, 1);
    chk("and_busy", busy, 0);
    tick();
    chk("and_done_pulse", done, 0);

    // ADD signed overflow
    issue(ADD_OP, 32'h7FFFFFFF, 32'h00000001);
    chk("add_done", done, 1);
    chk("add_result", result, 32'h80000000);
    chk("add_ovf", overflow, 1);
    chk("add_carry", carry, 0);
    chk("add_zero", zero, 0);

    // SUB with borrow
    issue(SUB_OP, 32'h0000FFFF, 32'hFFFF0000);
    chk("sub_result", result, 32'h0001FFFF);
    chk("sub_carry", carry, 0);
    chk("sub_ovf", overflow, 0);

    // SLT where a-b overflows
    issue(SLT_OP, 32'hAAAAAAAA, 32'h55555555);
    chk("slt1_result", result, 1);
    issue(SLT_OP, 32'h0000FFFF, 32'h0000000F);
    chk("slt0_result", result, 0);
    chk("slt0_zero", zero, 1);

    // Back-to-back single-cycle ops with start held high
    start = 1'b1;
    ALUop = OR_OP;  a = 32'hF0F00000; b = 32'h00000F0F; tick();
    chk("b2b_or_done", done, 1);
    chk("b2b_or_result", result, 32'hF0F00F0F);
    ALUop = XOR_OP; a = 32'hFF00FF00; b = 32'h0FF00FF0; tick();
    chk("b2b_xor_done", done, 1);
    chk("b2b_xor_result", result, 32'hF0F0F0F0);
    ALUop = NOR_OP; a = 32'h00000000; b = 32'h00000000; tick();
    chk("b2b_nor_done", done, 1);
    chk("b2b_nor_result", result, 32'hFFFFFFFF);
    ALUop = ADD_OP; a = 32'hFFFFFFFF; b = 32'h00000001; tick();
    chk("b2b_addc_result", result, 0);
    chk("b2b_addc_carry", carry, 1);
    chk("b2b_addc_zero", zero, 1);
    chk("b2b_addc_ovf", overflow, 0);
    ALUop = SUB_OP; a = 32'h80000000; b = 32'h00000001; tick();
    chk("b2b_subv_result", result, 32'h7FFFFFFF);
    chk("b2b_subv_ovf", overflow, 1);
    chk("b2b_subv_carry", carry, 1);
    start = 1'b0;
    a = 32'h12121212; b = 32'h34343434; ALUop = AND_OP;
    tick();
    tick();
    chk("hold_done", done, 0);
    chk("hold_result", result, 32'h7FFFFFFF);
    chk("hold_ovf", overflow, 1);

    // Remainder 32 % 9 with ignored starts at k+5 and k+20
    issue(MOD_OP, 32'd32, 32'd9);
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = 0;
    res_at   = '0;
    for (int i = 1; i <= 40; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = i;
          res_at  = result;
        end
      end
      if (i == 1) chk("mod_busy_k1", busy, 1);
      if (i == 32) chk("mod_busy_k32", busy, 1);
      if (i == 33) chk("mod_busy_k33", busy, 0);
      if (i == 5 || i == 20) begin
        start = 1'b1;
        ALUop = ADD_OP;
        a     = 32'd100;
        b     = 32'd3;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("mod_busy_cycles", busy_cnt, 32);
    chk("mod_done_count", done_cnt, 1);
    chk("mod_done_at", done_at, 33);
    chk("mod_result", res_at, 5);
    chk("mod_result_held", result, 5);

    // Start on the MOD done edge is refused; the next edge takes it
    issue(MOD_OP, 32'd20, 32'd6);
    wait_done(40, n, ok);
    chk("mod2_finished", ok, 1);
    chk("mod2_result", result, 2);
    ALUop = ADD_OP; a = 32'd1; b = 32'd2; start = 1'b1;
    tick();
    chk("doneedge_reject_done", done, 0);
    chk("doneedge_reject_result", result, 2);
    tick();
    start = 1'b0;
    chk("after_done_accept", done, 1);
    chk("after_done_result", result, 3);

    // Remainder with zero divisor
    issue(MOD_OP, 32'h12345678, 32'h0);
    chk("dbz_done", done, 1);
    chk("dbz_result", result, 32'h12345678);
    chk("dbz_flag", div_by_zero, 1);
    chk("dbz_busy", busy, 0);
    tick();
    chk("dbz_busy_after", busy, 0);
    chk("dbz_done_after", done, 0);
    chk("dbz_flag_held", div_by_zero, 1);

    // Reset during MOD aborts it
    issue(MOD_OP, 32'd1000, 32'd7);
    done_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      if (done === 1'b1) done_cnt++;
      reset = (i == 10) ? 1'b0 : 1'b1;
      tick();
    end
    reset = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_done", done, 0);
    chk("abort_zero", zero, 1);
    chk("abort_dbz", div_by_zero, 0);
    for (int i = 1; i <= 40; i++) begin
      if (done === 1'b1) done_cnt++;
      tick();
    end
    chk("abort_no_done", done_cnt, 0);
    issue(MOD_OP, 32'd1000, 32'd7);
    wait_done(40, n, ok);
    chk("mod3_finished", ok, 1);
    chk("mod3_latency", n + 1, 33);
    chk("mod3_result", result, 6);

    // Reset wins over start on the same edge
    reset = 1'b0;
    ALUop = ADD_OP; a = 32'd3; b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b1;
    chk("rstprio_done", done, 0);
    chk("rstprio_result", result, 0);
    tick();
    chk("rstprio_no_late_done", done, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
